// File: rtl/maxpool_layer3_if.sv
// maxpool_layer3_if
//   Bundles the streaming input side (8 channel samples, valid, last, ready)
//   and the pooled output side (8 channel maxima, valid, last, ready) of
//   maxpool_layer3.
//   Modports:
//     slave  - the pooling block: consumes Data_in*/in_valid/in_last/out_ready,
//              drives in_ready/Data_out*/out_valid/out_last.
//     master - the surrounding environment, directions mirrored.
interface maxpool_layer3_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] Data_in1, Data_in2, Data_in3, Data_in4;
  logic [WIDTH-1:0] Data_in5, Data_in6, Data_in7, Data_in8;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] Data_out1, Data_out2, Data_out3, Data_out4;
  logic [WIDTH-1:0] Data_out5, Data_out6, Data_out7, Data_out8;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  modport slave (
    input  Data_in1, Data_in2, Data_in3, Data_in4,
           Data_in5, Data_in6, Data_in7, Data_in8,
           in_valid, in_last, out_ready,
    output in_ready,
           Data_out1, Data_out2, Data_out3, Data_out4,
           Data_out5, Data_out6, Data_out7, Data_out8,
           out_valid, out_last
  );

  modport master (
    output Data_in1, Data_in2, Data_in3, Data_in4,
           Data_in5, Data_in6, Data_in7, Data_in8,
           in_valid, in_last, out_ready,
    input  in_ready,
           Data_out1, Data_out2, Data_out3, Data_out4,
           Data_out5, Data_out6, Data_out7, Data_out8,
           out_valid, out_last
  );
endinterface

// File: rtl/maxpool_layer3.sv
// maxpool_layer3
//   Streaming 8-channel max-pool placed after the layer-3 ReLU. Keeps a
//   running unsigned per-channel maximum over POOL accepted samples and emits
//   one pooled vector per completed window with a ready/valid output.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - maxpool_layer3_if.slave (input stream, pooled output stream)
//   Parameters: WIDTH (sample width, unsigned), POOL (window length, 2..16).
//   Build option: define MAXPOOL3_PARTIAL_FLUSH_EN to make an in_last sample
//   close a short window and emit it; otherwise short windows are dropped.
module maxpool_layer3 #(
  parameter int WIDTH = 8,
  parameter int POOL  = 2
) (
  input  logic             clk,
  input  logic             rst,
  maxpool_layer3_if.slave  bus
);
  localparam int CNT_W = $clog2(POOL);
  localparam logic [CNT_W-1:0] ST_START = '0;
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(POOL - 1);

`ifdef MAXPOOL3_PARTIAL_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] umax(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [WIDTH-1:0] din     [8];
  logic [WIDTH-1:0] acc_q   [8];
  logic [WIDTH-1:0] acc_d   [8];
  logic [WIDTH-1:0] dout_q  [8];
  logic [WIDTH-1:0] dout_d  [8];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovld_q, ovld_d;
  logic             olast_q, olast_d;
  logic             in_ready;
  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] merged;

  assign din[0] = bus.Data_in1;
  assign din[1] = bus.Data_in2;
  assign din[2] = bus.Data_in3;
  assign din[3] = bus.Data_in4;
  assign din[4] = bus.Data_in5;
  assign din[5] = bus.Data_in6;
  assign din[6] = bus.Data_in7;
  assign din[7] = bus.Data_in8;

  // Ready whenever the output register is empty or being drained this cycle.
  assign in_ready = !rst && (!ovld_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign complete = accept && ((cnt_q == ST_LAST) || (FLUSH && bus.in_last));

  always_comb begin
    cnt_d   = cnt_q;
    ovld_d  = ovld_q;
    olast_d = olast_q;
    merged  = '0;
    for (int k = 0; k < 8; k++) begin
      acc_d[k]  = acc_q[k];
      dout_d[k] = dout_q[k];
    end

    // Drain first; a completion in the same cycle re-asserts valid below.
    if (ovld_q && bus.out_ready) begin
      ovld_d  = 1'b0;
      olast_d = 1'b0;
    end

    if (accept) begin
      for (int k = 0; k < 8; k++) begin
        merged   = (cnt_q == ST_START) ? din[k] : umax(acc_q[k], din[k]);
        acc_d[k] = merged;
        if (complete) dout_d[k] = merged;
      end
      if (complete) begin
        ovld_d  = 1'b1;
        olast_d = bus.in_last;
        cnt_d   = ST_START;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // End of frame always restarts the window, dropping any short remainder.
      if (bus.in_last) cnt_d = ST_START;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= ST_START;
      ovld_q  <= 1'b0;
      olast_q <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        acc_q[k]  <= '0;
        dout_q[k] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      ovld_q  <= ovld_d;
      olast_q <= olast_d;
      for (int k = 0; k < 8; k++) begin
        acc_q[k]  <= acc_d[k];
        dout_q[k] <= dout_d[k];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ovld_q;
  assign bus.out_last  = olast_q;
  assign bus.Data_out1 = dout_q[0];
  assign bus.Data_out2 = dout_q[1];
  assign bus.Data_out3 = dout_q[2];
  assign bus.Data_out4 = dout_q[3];
  assign bus.Data_out5 = dout_q[4];
  assign bus.Data_out6 = dout_q[5];
  assign bus.Data_out7 = dout_q[6];
  assign bus.Data_out8 = dout_q[7];
endmodule

// File: tb/tb_maxpool_layer3.sv
module tb_maxpool_layer3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] din [8];
  logic       in_valid = 1'b0;
  logic       in_last  = 1'b0;
  logic       out_ready = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  maxpool_layer3_if #(.WIDTH(8)) bus ();

  assign bus.Data_in1 = din[0];
  assign bus.Data_in2 = din[1];
  assign bus.Data_in3 = din[2];
  assign bus.Data_in4 = din[3];
  assign bus.Data_in5 = din[4];
  assign bus.Data_in6 = din[5];
  assign bus.Data_in7 = din[6];
  assign bus.Data_in8 = din[7];
  assign bus.in_valid  = in_valid;
  assign bus.in_last   = in_last;
  assign bus.out_ready = out_ready;

  maxpool_layer3 #(.WIDTH(8), .POOL(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_din();
    for (int k = 0; k < 8; k++) din[k] = 8'd0;
  endtask

  task automatic wait_out_valid(input int max_cycles);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $error("FAIL wait_out_valid expired after %0d cycles", max_cycles);
    end
  endtask

  initial begin
    #100000;
    errors++;
    $error("FAIL watchdog expired: simulation did not finish");
    $finish;
  end

  initial begin
    clear_din();
    rst = 1'b1; in_valid = 1'b1; din[0] = 8'd99;
    tick(); tick();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $error("FAIL reset_state in_ready=%0b out_valid=%0b", bus.in_ready, bus.out_valid);
    end
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_dout1", bus.Data_out1, 8'd0);
    rst = 1'b0; in_valid = 1'b0; clear_din();
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);

    in_valid = 1'b1;
    din[0] = 8'd5; din[7] = 8'd200; din[3] = 8'd7;
    tick();
    chk("basic_no_out_yet", bus.out_valid, 1'b0);
    din[0] = 8'd9; din[7] = 8'd3; din[3] = 8'd7;
    tick();
    wait_out_valid(4);
    chk("basic_valid", bus.out_valid, 1'b1);
    chk("basic_d1", bus.Data_out1, 8'd9);
    chk("basic_d8", bus.Data_out8, 8'd200);
    chk("basic_tie_d4", bus.Data_out4, 8'd7);
    chk("basic_d2", bus.Data_out2, 8'd0);
    chk("basic_last", bus.out_last, 1'b0);
    in_valid = 1'b0; clear_din();
    tick();
    chk("basic_drain", bus.out_valid, 1'b0);
    chk("basic_hold_d1", bus.Data_out1, 8'd9);

    in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      din[0] = 8'(i);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $error("FAIL b2b_in_ready i=%0d observed=%0b", i, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== ((i % 2) == 0)) begin
        errors++;
        $error("FAIL b2b_valid i=%0d observed=%0b", i, bus.out_valid);
      end
      if ((i % 2) == 0) begin
        checks++;
        if (bus.Data_out1 !== 8'(i)) begin
          errors++;
          $error("FAIL b2b_d1 i=%0d observed=%0d", i, bus.Data_out1);
        end
      end
    end
    in_valid = 1'b0; clear_din();
    tick();

    out_ready = 1'b0; in_valid = 1'b1;
    din[2] = 8'd77; tick();
    din[2] = 8'd10; tick();
    chk("bp_valid", bus.out_valid, 1'b1);
    chk("bp_d3", bus.Data_out3, 8'd77);
    chk("bp_in_ready", bus.in_ready, 1'b0);
    din[2] = 8'd200;
    tick(); tick();
    chk("bp_valid_held", bus.out_valid, 1'b1);
    chk("bp_d3_held", bus.Data_out3, 8'd77);
    chk("bp_in_ready_held", bus.in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", bus.in_ready, 1'b1);
    tick();
    chk("bp_drained", bus.out_valid, 1'b0);
    din[2] = 8'd5; tick();
    chk("bp_stalled_counted_once", bus.out_valid, 1'b1);
    chk("bp_next_d3", bus.Data_out3, 8'd200);
    in_valid = 1'b0; clear_din();
    tick();

    in_valid = 1'b1;
    din[1] = 8'd1; tick();
    din[1] = 8'd2; tick();
    chk("part_first_valid", bus.out_valid, 1'b1);
    chk("part_first_d2", bus.Data_out2, 8'd2);
    chk("part_first_last", bus.out_last, 1'b0);
    din[1] = 8'd40; in_last = 1'b1; tick();
`ifdef MAXPOOL3_PARTIAL_FLUSH_EN
    chk("part_flush_valid", bus.out_valid, 1'b1);
    chk("part_flush_d2", bus.Data_out2, 8'd40);
    chk("part_flush_last", bus.out_last, 1'b1);
`else
    chk("part_drop_valid", bus.out_valid, 1'b0);
    chk("part_drop_last", bus.out_last, 1'b0);
    chk("part_drop_d2_kept", bus.Data_out2, 8'd2);
`endif
    in_last = 1'b0;
    din[1] = 8'd3; tick();
    chk("part_restart_no_out", bus.out_valid, 1'b0);
    din[1] = 8'd4; tick();
    chk("part_restart_valid", bus.out_valid, 1'b1);
    chk("part_restart_d2", bus.Data_out2, 8'd4);
    din[1] = 8'd6; tick();
    din[1] = 8'd5; in_last = 1'b1; tick();
    chk("full_last_valid", bus.out_valid, 1'b1);
    chk("full_last_d2", bus.Data_out2, 8'd6);
    chk("full_last_flag", bus.out_last, 1'b1);
    in_last = 1'b0; in_valid = 1'b0; clear_din();
    tick();
    chk("full_last_drained", bus.out_last, 1'b0);

    in_valid = 1'b1; din[0] = 8'd250; tick();
    in_valid = 1'b0; rst = 1'b1; tick();
    chk("rmw_in_ready", bus.in_ready, 1'b0);
    rst = 1'b0; in_valid = 1'b1;
    din[0] = 8'd10; tick();
    chk("rmw_no_out", bus.out_valid, 1'b0);
    din[0] = 8'd20; tick();
    chk("rmw_valid", bus.out_valid, 1'b1);
    chk("rmw_d1", bus.Data_out1, 8'd20);

    out_ready = 1'b0;
    tick();
    din[0] = 8'd0; din[7] = 8'd0; tick();
    in_valid = 1'b0; clear_din();
    out_ready = 1'b1; tick();
    out_ready = 1'b0; in_valid = 1'b1;
    din[7] = 8'd33; tick();
    din[7] = 8'd44; in_last = 1'b1; tick();
    chk("rds_pre_valid", bus.out_valid, 1'b1);
    chk("rds_pre_last", bus.out_last, 1'b1);
    chk("rds_pre_d8", bus.Data_out8, 8'd44);
    in_valid = 1'b0; in_last = 1'b0; rst = 1'b1; tick();
    chk("rds_valid", bus.out_valid, 1'b0);
    chk("rds_last", bus.out_last, 1'b0);
    chk("rds_d8", bus.Data_out8, 8'd0);
    chk("rds_d1", bus.Data_out1, 8'd0);
    rst = 1'b0; out_ready = 1'b1;
    tick();
    chk("rds_no_late_out", bus.out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/maxpool_layer3.md
# maxpool_layer3

Streaming 8-channel max-pooling stage placed directly downstream of the layer-3 ReLU. It accepts one 8-channel activation vector per handshake and tracks a running per-channel maximum over POOL consecutive samples. It emits one pooled 8-channel vector per completed window to the next convolution/dense stage. Frame boundaries are marked with `last` flags, and the output side supports backpressure with a ready/valid handshake.

## Interface
- `WIDTH`, 8: bit width of each channel sample. Samples are unsigned, since the ReLU output is non-negative.
- `POOL`, 2: pooling window length in samples. Legal range is 2..16.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `Data_in1`..`Data_in8`  in  WIDTH each  channel samples from the ReLU stage.
- `in_valid`  in  1  the input vector is valid.
- `in_last`  in  1  this input vector is the final sample of the ECG frame.
- `in_ready`  out  1  the block can accept the input vector this cycle.
- `Data_out1`..`Data_out8`  out  WIDTH each  pooled per-channel maxima.
- `out_valid`  out  1  the pooled vector is valid.
- `out_last`  out  1  the pooled vector closes the frame.
- `out_ready`  in  1  the downstream stage accepts the pooled vector.

## Operation
- **Accept rule:** a transfer occurs when `in_valid && in_ready`.
- **`in_ready` definition:** `in_ready = !rst && (!out_valid || out_ready)`. It is combinational and holds no state.
- **Window state:** a counter `cnt` runs 0..POOL-1 and acts as the state machine. `cnt==0` is the window-start state; the other values are accumulate states.
- **Accepted sample, `cnt==0`:** `acc_k <= Data_ink` for every channel k.
- **Accepted sample, `cnt>0`:** `acc_k <= max(acc_k, Data_ink)`, using an unsigned comparison.
- **Window completion:** a window completes on an accepted sample when `cnt==POOL-1`, or when `in_last=1` and the flush feature is enabled.
- **On completion:**
  - `Data_outk <= (cnt==0) ? Data_ink : max(acc_k, Data_ink)`.
  - `out_valid <= 1`.
  - `out_last <= in_last`.
  - `cnt <= 0`.
- **No completion:** `cnt <= cnt+1`. However, `in_last=1` always forces `cnt <= 0`, whether or not the window completed.
- **Output hold:** `Data_out*` and `out_last` stay stable while `out_valid && !out_ready`.
- **Output drain:** when `out_valid && out_ready` and no completion happens in the same cycle, `out_valid <= 0` and `out_last <= 0`. `Data_out*` keeps its last value.
- **Simultaneous drain and completion:** the new vector is loaded and `out_valid` stays at 1, giving back-to-back throughput.
- **Equal values:** ties produce the same value on the output, so no tie-break rule is needed.
- **No saturation or width growth:** the output width equals the input width.

## Timing
- **Reset values:**
  - `cnt=0`, `acc_k=0`.
  - `Data_out1..8=0`, `out_valid=0`, `out_last=0`.
  - `in_ready=0` while `rst=1`, and 1 on the first cycle after reset is released.
- **Latency:** `out_valid` rises on the clock edge that accepts the final sample of a window. The pooled vector is therefore visible 1 cycle after the final accept.
- **Throughput:** one sample per cycle when `out_ready` is held high. With POOL=2, one output is produced every 2 input cycles.
- **Backpressure:** while `out_valid && !out_ready`, `in_ready=0`. A stalled sample is neither consumed nor counted.
- **Reset mid-window or mid-stall:**
  - The partial window and any pending output are discarded.
  - No output is produced for those samples after reset is released.
- **Input during `rst`:** `in_valid` asserted during `rst` is ignored.

## Configuration
- **Macro `MAXPOOL3_PARTIAL_FLUSH_EN`, defined:** an `in_last` sample that arrives with `cnt<POOL-1` completes a short window. The block emits the max of the samples received so far, with `out_last=1`.
- **Macro `MAXPOOL3_PARTIAL_FLUSH_EN`, undefined:**
  - A short window ended by `in_last` is silently dropped and `cnt` returns to 0.
  - `out_last` is asserted only when `in_last` coincides with `cnt==POOL-1`.

## Test plan
- **Basic max, POOL=2, `out_ready=1`:** ch1 inputs 5 then 9, ch8 inputs 200 then 3 → one output with `Data_out1=9` and `Data_out8=200`, asserted 1 cycle after the 2nd accept, `out_last=0`.
- **Back-to-back, POOL=2:** 8 consecutive vectors with ch1 = 1,2,...,8 and `out_ready=1` → 4 outputs with ch1 = 2,4,6,8. There is no bubble on the input, and `in_ready` stays high throughout.
- **Backpressure:** hold `out_ready=0` after a window completes with ch3 = 77 → `out_valid` is held, `Data_out3=77` is stable, and `in_ready=0`. Release `out_ready` → the transfer occurs and `in_ready` returns to 1 in the same cycle.
- **Partial frame, POOL=2, 3 samples, last sample ch2 = 40 with `in_last=1`:**
  - With the flush macro: a second output with `Data_out2=40` and `out_last=1`.
  - Without the flush macro: only the first output appears, with `out_last=0`, and `cnt=0` afterwards.
- **Reset mid-window:** accept 1 sample (ch1 = 250), pulse `rst` for 1 cycle, then send 2 samples with ch1 = 10 and 20 → the output has ch1 = 20, not 250.
- **Reset during stall:** `out_valid=1` and `out_ready=0`, assert `rst` → the next cycle shows `out_valid=0`, `Data_out*=0`, and `out_last=0`.
